writeback_stage: RTL and testbench
==================================

# writeback_stage

MEM/WB pipeline register and write-back selector that sits directly upstream of the register file's write port. Captures one retiring instruction per cycle from the memory stage, selects the write-back source, and drives `Reg_Write`/`Write_Register`/`Write_Data` into the register file one cycle later. It also inserts bubbles on stall/flush, suppresses writes to register 0, and counts retired instructions.

## Interface
- `N`, 32, data width of all data paths and of the retire counter.
- `clk`  in  1  rising-edge clock.
- `reset`  in  1  asynchronous, active-low reset.
- `Valid_i`  in  1  MEM stage holds a real instruction this cycle.
- `Stall_i`  in  1  hazard unit stall; the stage inserts a bubble and holds data outputs.
- `Flush_i`  in  1  squash; the stage inserts a bubble and clears data outputs. Has priority over `Stall_i`.
- `Reg_Write_i`  in  1  instruction writes a register.
- `Mem_To_Reg_i`  in  2  source select: 0 ALU result, 1 memory data, 2 `PC_Plus_4_i` (link), 3 `{Imm_i[15:0],16'b0}` (LUI).
- `Write_Register_i`  in  5  destination register.
- `ALU_Result_i`  in  N  ALU result; bits [1:0] are the load byte offset.
- `Mem_Data_i`  in  N  word read from data memory.
- `PC_Plus_4_i`  in  N  link address.
- `Imm_i`  in  16  immediate field.
- `Mem_Size_i`  in  2  load size: 0 byte, 1 half, 2/3 word. Used only with `LOAD_EXTEND_EN`.
- `Mem_Unsigned_i`  in  1  zero-extend sub-word loads. Used only with `LOAD_EXTEND_EN`.
- `Reg_Write_o`  out  1  write enable to the register file.
- `Write_Register_o`  out  5  register file write address.
- `Write_Data_o`  out  N  register file write data.
- `Retire_Count_o`  out  N  number of instructions retired since reset.

## Operation
- **Capture condition.** Define `accept = Valid_i & ~Stall_i & ~Flush_i`.
- **On accept:**
  - `Write_Register_o` ← `Write_Register_i`.
  - `Write_Data_o` ← the selected source.
  - `Reg_Write_o` ← `Reg_Write_i & (Write_Register_i != 0)`.
  - `Retire_Count_o` increments by 1. It wraps from 2^N−1 to 0 with no flag.
- **Stall with no flush:** `Reg_Write_o` ← 0. `Write_Register_o` and `Write_Data_o` hold. The counter holds.
- **Flush:** `Reg_Write_o` ← 0, `Write_Register_o` ← 0, `Write_Data_o` ← 0. The counter holds. This applies whatever the state of `Stall_i` and `Valid_i`.
- **`Valid_i`=0 with no stall or flush:** bubble. `Reg_Write_o` ← 0 and data outputs hold. The counter holds.
- **Retirement:** a retired instruction is any accepted one, including those with `Reg_Write_i`=0 (stores, branches) and those targeting register 0.
- **Register 0 writes:** a write to register 0 retires, but `Reg_Write_o` stays 0. `Write_Data_o` still updates.
- **Data path:** source selection and load extension are combinational in front of the register. Nothing is combinational from inputs to outputs.

## Timing
- **Latency:** 1 cycle. Inputs are sampled at rising edge k; outputs are valid after edge k and the register file writes them at edge k+1.
- **Throughput:** one instruction per cycle. No backpressure is generated; stall and flush come from upstream control.
- **Reset (asynchronous assert, `reset`=0):** `Reg_Write_o`=0, `Write_Register_o`=0, `Write_Data_o`=0, `Retire_Count_o`=0.
- **Reset release:** the first capture is at the first rising edge with `reset`=1.
- **Reset mid-operation:** the in-flight instruction is lost and not counted. Outputs go to reset values immediately, not at the next edge.
- **Back-to-back writes to the same register:** each is presented in its own cycle and the last one wins. This stage does no merging.

## Configuration
- **Macro:** `LOAD_EXTEND_EN`.
- **Defined:** for `Mem_To_Reg_i`=1, the load is extracted according to `Mem_Size_i`.
  - **Byte:** takes `Mem_Data_i[8*off+7:8*off]`, where `off = ALU_Result_i[1:0]`.
  - **Half:** takes `Mem_Data_i[16*off[1]+15:16*off[1]]`. `off[0]` is ignored; no misalignment trap.
  - **Word:** passes `Mem_Data_i` unchanged.
  - **Extension:** sub-word results are sign-extended, or zero-extended when `Mem_Unsigned_i`=1.
- **Not defined:** `Mem_To_Reg_i`=1 passes `Mem_Data_i` unchanged. `Mem_Size_i` and `Mem_Unsigned_i` are ignored.

## Test plan
- **Reset:** `reset`=0 mid-run with `Reg_Write_o`=1 → all outputs read 0 before the next clock edge; `Retire_Count_o`=0.
- **ALU writeback:** `Valid_i`=1, `Reg_Write_i`=1, `Mem_To_Reg_i`=0, `Write_Register_i`=7, `ALU_Result_i`=8 → next cycle `Reg_Write_o`=1, `Write_Register_o`=7, `Write_Data_o`=8, count=1.
- **Link, LUI and register 0:**
  - Select 2 with `PC_Plus_4_i`=0x40 → `Write_Data_o`=0x40.
  - Select 3 with `Imm_i`=0x1234 → `Write_Data_o`=0x12340000.
  - `Write_Register_i`=0 → `Reg_Write_o`=0 and the counter still increments.
- **Stall and flush:**
  - Write of 45 to register 17, then `Stall_i`=1 for 2 cycles → `Reg_Write_o`=0, outputs hold 17/45, count unchanged.
  - `Flush_i`=1 together with `Stall_i`=1 → `Reg_Write_o`=0, register and data outputs 0.
- **`LOAD_EXTEND_EN`:** `Mem_Data_i`=0x80FF7F01, `Mem_To_Reg_i`=1.
  - Byte, offset 3, signed → 0xFFFFFF80.
  - Byte, offset 3, unsigned → 0x00000080.
  - Half, offset 2, signed → 0xFFFF80FF.
  - Without the macro, the same stimulus → 0x80FF7F01.
- **Counter wrap:** N=8, 256 accepted instructions → `Retire_Count_o` returns to 0.

Source files
------------

// File: rtl/writeback_stage.sv
// MEM/WB pipeline register with write-back source select, bubble/flush handling,
// register-0 write suppression and a retired-instruction counter.
// Optional sub-word load extraction is built when LOAD_EXTEND_EN is defined.
module writeback_stage #(
  parameter int N = 32
) (
  input  logic         clk,
  input  logic         reset,
  input  logic         Valid_i,
  input  logic         Stall_i,
  input  logic         Flush_i,
  input  logic         Reg_Write_i,
  input  logic [1:0]   Mem_To_Reg_i,
  input  logic [4:0]   Write_Register_i,
  input  logic [N-1:0] ALU_Result_i,
  input  logic [N-1:0] Mem_Data_i,
  input  logic [N-1:0] PC_Plus_4_i,
  input  logic [15:0]  Imm_i,
  input  logic [1:0]   Mem_Size_i,
  input  logic         Mem_Unsigned_i,
  output logic         Reg_Write_o,
  output logic [4:0]   Write_Register_o,
  output logic [N-1:0] Write_Data_o,
  output logic [N-1:0] Retire_Count_o
);

  typedef enum logic [1:0] {
    SRC_ALU  = 2'd0,
    SRC_MEM  = 2'd1,
    SRC_LINK = 2'd2,
    SRC_LUI  = 2'd3
  } wb_src_e;

  logic         accept;
  logic [N-1:0] load_data;
  logic [N-1:0] wb_data;

  assign accept = Valid_i & ~Stall_i & ~Flush_i;

`ifdef LOAD_EXTEND_EN
  logic [31:0] mem_word;
  logic [7:0]  load_byte;
  logic [15:0] load_half;

  // Offset bits come from the low address bits of the load's effective address.
  always_comb begin
    mem_word  = 32'(Mem_Data_i);
    load_byte = mem_word[{ALU_Result_i[1:0], 3'b000} +: 8];
    load_half = mem_word[{ALU_Result_i[1], 4'b0000} +: 16];
    case (Mem_Size_i)
      2'd0:    load_data = N'({{24{load_byte[7] & ~Mem_Unsigned_i}}, load_byte});
      2'd1:    load_data = N'({{16{load_half[15] & ~Mem_Unsigned_i}}, load_half});
      default: load_data = Mem_Data_i;
    endcase
  end
`else
  logic unused_load_ctrl;

  assign unused_load_ctrl = ^{Mem_Size_i, Mem_Unsigned_i};
  assign load_data        = Mem_Data_i;
`endif

  // NOTE: wb_data gets a default before the case so no path leaves it unassigned (no latch).
  always_comb begin
    wb_data = '0;
    case (wb_src_e'(Mem_To_Reg_i))
      SRC_ALU:  wb_data = ALU_Result_i;
      SRC_MEM:  wb_data = load_data;
      SRC_LINK: wb_data = PC_Plus_4_i;
      SRC_LUI:  wb_data = N'({Imm_i, 16'h0000});
      default:  wb_data = '0;
    endcase
  end

  // NOTE: state updates use non-blocking assignments so all registers sample pre-edge values.
  always_ff @(posedge clk or negedge reset) begin
    if (!reset) begin
      Reg_Write_o      <= 1'b0;
      Write_Register_o <= '0;
      Write_Data_o     <= '0;
      Retire_Count_o   <= '0;
    end else if (Flush_i) begin
      Reg_Write_o      <= 1'b0;
      Write_Register_o <= '0;
      Write_Data_o     <= '0;
    end else if (accept) begin
      Reg_Write_o      <= Reg_Write_i & (Write_Register_i != 5'd0);
      Write_Register_o <= Write_Register_i;
      Write_Data_o     <= wb_data;
      Retire_Count_o   <= Retire_Count_o + N'(1);
    end else begin
      // Stall or empty slot: bubble, data outputs hold.
      Reg_Write_o      <= 1'b0;
    end
  end

endmodule

// File: tb/tb_writeback_stage.sv
// Self-checking bench for writeback_stage: directed cases, randomized traffic
// against a behavioural model, mid-run reset and an 8-bit counter wrap instance.
module tb_writeback_stage;

  logic        clk = 1'b0;
  logic        reset;
  logic        valid, stall, flush, reg_write, mem_uns;
  logic [1:0]  mem_to_reg, mem_size;
  logic [4:0]  wr_reg;
  logic [31:0] alu, mem_data, pc4;
  logic [15:0] imm;
  logic        rw_o;
  logic [4:0]  wr_o;
  logic [31:0] wd_o, cnt_o;

  logic        v8;
  logic [7:0]  a8;
  logic        rw8;
  logic [4:0]  wr8;
  logic [7:0]  wd8, cnt8;

  int n_checks = 0;
  int n_pass   = 0;

  // Reference model state.
  logic        m_rw;
  logic [4:0]  m_wr;
  logic [31:0] m_wd, m_cnt;

  always #5 clk = ~clk;

  writeback_stage #(.N(32)) dut (
    .clk(clk), .reset(reset), .Valid_i(valid), .Stall_i(stall), .Flush_i(flush),
    .Reg_Write_i(reg_write), .Mem_To_Reg_i(mem_to_reg), .Write_Register_i(wr_reg),
    .ALU_Result_i(alu), .Mem_Data_i(mem_data), .PC_Plus_4_i(pc4), .Imm_i(imm),
    .Mem_Size_i(mem_size), .Mem_Unsigned_i(mem_uns),
    .Reg_Write_o(rw_o), .Write_Register_o(wr_o), .Write_Data_o(wd_o),
    .Retire_Count_o(cnt_o)
  );

  writeback_stage #(.N(8)) dut8 (
    .clk(clk), .reset(reset), .Valid_i(v8), .Stall_i(1'b0), .Flush_i(1'b0),
    .Reg_Write_i(1'b1), .Mem_To_Reg_i(2'd0), .Write_Register_i(5'd9),
    .ALU_Result_i(a8), .Mem_Data_i(8'h00), .PC_Plus_4_i(8'h00), .Imm_i(16'h0000),
    .Mem_Size_i(2'd0), .Mem_Unsigned_i(1'b0),
    .Reg_Write_o(rw8), .Write_Register_o(wr8), .Write_Data_o(wd8),
    .Retire_Count_o(cnt8)
  );

  task automatic check(input string tag, input logic [31:0] got, input logic [31:0] exp);
    n_checks++;
    if (got === exp) n_pass++;
    else $display("FAIL %s: got 0x%08h expected 0x%08h", tag, got, exp);
  endtask

  function automatic logic [31:0] load_model(input logic [31:0] mem, input logic [1:0] off,
                                             input logic [1:0] size, input logic uns);
    logic [31:0] v;
    v = mem;
`ifdef LOAD_EXTEND_EN
    if (size == 2'd0) begin
      v = (mem >> (8 * off)) & 32'hFF;
      if (!uns && v >= 32'd128) v = v + 32'hFFFF_FF00;
    end else if (size == 2'd1) begin
      v = (mem >> (16 * (off / 2))) & 32'hFFFF;
      if (!uns && v >= 32'd32768) v = v + 32'hFFFF_0000;
    end
`else
    if (size == 2'd3 && uns) v = mem;  // size and signedness have no effect here
`endif
    return v;
  endfunction

  function automatic logic [31:0] source_model();
    case (mem_to_reg)
      2'd0:    return alu;
      2'd1:    return load_model(mem_data, alu[1:0], mem_size, mem_uns);
      2'd2:    return pc4;
      default: return imm * 32'd65536;
    endcase
  endfunction

  task automatic drive(input logic v, input logic s, input logic f, input logic rw,
                       input logic [1:0] sel, input logic [4:0] rd, input logic [31:0] a,
                       input logic [31:0] md, input logic [31:0] pc, input logic [15:0] im,
                       input logic [1:0] sz, input logic un);
    valid = v; stall = s; flush = f; reg_write = rw; mem_to_reg = sel; wr_reg = rd;
    alu = a; mem_data = md; pc4 = pc; imm = im; mem_size = sz; mem_uns = un;
  endtask

  // One clock: model applies the spec rules at the edge, then all outputs are compared.
  task automatic cycle(input string tag);
    @(posedge clk);
    if (flush) begin
      m_rw = 1'b0; m_wr = 5'd0; m_wd = 32'd0;
    end else if (valid && !stall) begin
      m_wd  = source_model();
      m_wr  = wr_reg;
      m_rw  = reg_write && (wr_reg != 5'd0);
      m_cnt = m_cnt + 32'd1;
    end else begin
      m_rw = 1'b0;
    end
    #1;
    check({tag, ".rw"},  {31'd0, rw_o}, {31'd0, m_rw});
    check({tag, ".wr"},  {27'd0, wr_o}, {27'd0, m_wr});
    check({tag, ".wd"},  wd_o, m_wd);
    check({tag, ".cnt"}, cnt_o, m_cnt);
  endtask

  initial begin
    logic [31:0] exp_load;
    reset = 1'b0;
    v8 = 1'b0; a8 = 8'd0;
    drive(0, 0, 0, 0, 0, 0, 0, 0, 0, 0, 0, 0);
    m_rw = 0; m_wr = 0; m_wd = 0; m_cnt = 0;
    #12;
    check("reset.rw",  {31'd0, rw_o}, 32'd0);
    check("reset.wd",  wd_o, 32'd0);
    check("reset.cnt", cnt_o, 32'd0);
    @(negedge clk) reset = 1'b1;

    // Directed cases.
    drive(1, 0, 0, 1, 0, 7, 32'd8, 0, 0, 0, 0, 0);                cycle("alu");
    check("alu.fixed_wd", wd_o, 32'd8);
    check("alu.fixed_cnt", cnt_o, 32'd1);
    drive(1, 0, 0, 1, 2, 31, 0, 0, 32'h40, 0, 0, 0);              cycle("link");
    check("link.fixed_wd", wd_o, 32'h40);
    drive(1, 0, 0, 1, 3, 4, 0, 0, 0, 16'h1234, 0, 0);             cycle("lui");
    check("lui.fixed_wd", wd_o, 32'h1234_0000);
    drive(1, 0, 0, 1, 0, 0, 32'h55, 0, 0, 0, 0, 0);               cycle("reg0");
    check("reg0.fixed_rw", {31'd0, rw_o}, 32'd0);
    check("reg0.fixed_cnt", cnt_o, 32'd4);
    drive(1, 0, 0, 1, 0, 17, 32'd45, 0, 0, 0, 0, 0);              cycle("w17");
    drive(1, 1, 0, 1, 0, 3, 32'd99, 0, 0, 0, 0, 0);               cycle("stall1");
    cycle("stall2");
    check("stall.hold_wr", {27'd0, wr_o}, 32'd17);
    check("stall.hold_wd", wd_o, 32'd45);
    check("stall.hold_cnt", cnt_o, 32'd5);
    drive(0, 0, 0, 1, 0, 3, 32'd77, 0, 0, 0, 0, 0);               cycle("bubble");
    drive(1, 1, 1, 1, 0, 3, 32'd99, 0, 0, 0, 0, 0);               cycle("flush");
    check("flush.fixed_wd", wd_o, 32'd0);

    // Sub-word loads from 0x80FF7F01.
`ifdef LOAD_EXTEND_EN
    exp_load = 32'hFFFF_FF80;
`else
    exp_load = 32'h80FF_7F01;
`endif
    drive(1, 0, 0, 1, 1, 5, 32'h103, 32'h80FF_7F01, 0, 0, 0, 0);  cycle("lb3");
    check("lb3.fixed", wd_o, exp_load);
`ifdef LOAD_EXTEND_EN
    exp_load = 32'h0000_0080;
`endif
    drive(1, 0, 0, 1, 1, 5, 32'h103, 32'h80FF_7F01, 0, 0, 0, 1);  cycle("lbu3");
    check("lbu3.fixed", wd_o, exp_load);
`ifdef LOAD_EXTEND_EN
    exp_load = 32'hFFFF_80FF;
`endif
    drive(1, 0, 0, 1, 1, 5, 32'h102, 32'h80FF_7F01, 0, 0, 1, 0);  cycle("lh2");
    check("lh2.fixed", wd_o, exp_load);

    // Randomized traffic against the model.
    for (int i = 0; i < 300; i++) begin
      drive($urandom_range(3, 0) != 0, $urandom_range(4, 0) == 0, $urandom_range(9, 0) == 0,
            1'($urandom), 2'($urandom), 5'($urandom), $urandom, $urandom, $urandom,
            16'($urandom), 2'($urandom), 1'($urandom));
      cycle("rand");
    end

    // Mid-run reset with a write pending on the outputs.
    drive(1, 0, 0, 1, 0, 3, 32'hCAFE, 0, 0, 0, 0, 0);             cycle("pre_rst");
    check("pre_rst.rw_high", {31'd0, rw_o}, 32'd1);
    #3 reset = 1'b0;
    #1;
    check("midrst.rw",  {31'd0, rw_o}, 32'd0);
    check("midrst.wr",  {27'd0, wr_o}, 32'd0);
    check("midrst.wd",  wd_o, 32'd0);
    check("midrst.cnt", cnt_o, 32'd0);
    @(posedge clk) #1;
    check("midrst.held_cnt", cnt_o, 32'd0);
    m_rw = 0; m_wr = 0; m_wd = 0; m_cnt = 0;
    @(negedge clk) reset = 1'b1;
    drive(1, 0, 0, 1, 0, 6, 32'h1111, 0, 0, 0, 0, 0);             cycle("post_rst");
    drive(0, 0, 0, 0, 0, 0, 0, 0, 0, 0, 0, 0);

    // 8-bit counter wraps after 256 accepted instructions.
    for (int i = 0; i < 256; i++) begin
      @(negedge clk);
      v8 = 1'b1;
      a8 = 8'(i);
      @(posedge clk) #1;
      if (i == 0)   check("wrap.first_wd", {24'd0, wd8}, 32'd0);
      if (i == 254) check("wrap.cnt255", {24'd0, cnt8}, 32'd255);
    end
    check("wrap.cnt0", {24'd0, cnt8}, 32'd0);
    check("wrap.last_wd", {24'd0, wd8}, 32'd255);
    check("wrap.rw", {31'd0, rw8}, 32'd1);
    check("wrap.wr", {27'd0, wr8}, 32'd9);
    @(negedge clk) v8 = 1'b0;

    $display("%0d/%0d checks passed", n_pass, n_checks);
    $finish;
  end

endmodule
